// File: rtl/bsg_async_fifo_wptr_ctrl.sv
// Write-side controller for a gray-pointer async FIFO: fullness gating,
// post-reset settling and a flush (drain-to-empty) handshake.
module bsg_async_fifo_wptr_ctrl #(
    parameter int unsigned lg_size_p            = 6,
    parameter int unsigned settle_cycles_p      = 4,
    parameter int unsigned almost_full_thresh_p = 28
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    input  logic                 v_i,
    output logic                 ready_o,
    output logic                 w_inc_o,
    input  logic [lg_size_p-1:0] w_ptr_binary_i,
    input  logic [lg_size_p-1:0] r_ptr_gray_wsync_i,
    input  logic                 flush_i,
    output logic                 flush_done_o,
    output logic                 full_o,
    output logic                 almost_full_o,
    output logic [lg_size_p-1:0] occupancy_o
);

    localparam int unsigned DEPTH = 2 ** (lg_size_p - 1);
    localparam int unsigned CW    = $clog2(settle_cycles_p + 1);

    typedef enum logic [1:0] {
        SETTLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t                 r_state, w_state_nxt;
    logic [CW-1:0]          r_settle_cnt, w_settle_cnt_nxt;
    logic                   r_flush_pend, w_flush_pend_nxt;
    logic [lg_size_p-1:0]   r_bin;
    logic [lg_size_p-1:0]   w_gray_bin;
    logic [lg_size_p-1:0]   w_occupancy;

    // Each binary bit is the XOR of all gray bits at or above it.
    always_comb begin
        w_gray_bin = '0;
        for (int unsigned i = 0; i < lg_size_p; i++) begin
            w_gray_bin[i] = ^(r_ptr_gray_wsync_i >> i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_bin <= '0;
        end else begin
            r_bin <= w_gray_bin;
        end
    end

    // Modular subtraction: pointer wrap yields the correct count directly.
    assign w_occupancy   = w_ptr_binary_i - r_bin;
    assign occupancy_o   = w_occupancy;
    assign full_o        = (w_occupancy == lg_size_p'(DEPTH));
    assign almost_full_o = (w_occupancy >= lg_size_p'(almost_full_thresh_p));

    assign ready_o      = (r_state == RUN) && !full_o;
    assign w_inc_o      = v_i && ready_o;
    assign flush_done_o = (r_state == DONE);

    always_comb begin
        w_state_nxt      = r_state;
        w_settle_cnt_nxt = r_settle_cnt;
        w_flush_pend_nxt = r_flush_pend;
        case (r_state)
            SETTLE: begin
                w_settle_cnt_nxt = r_settle_cnt - CW'(1);
                w_flush_pend_nxt = r_flush_pend || flush_i;
                if (r_settle_cnt == CW'(1)) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (flush_i || r_flush_pend) begin
                    w_state_nxt      = DRAIN;
                    w_flush_pend_nxt = 1'b0;
                end
            end
            DRAIN: begin
                w_flush_pend_nxt = r_flush_pend || flush_i;
                if (w_occupancy == '0) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_flush_pend_nxt = r_flush_pend || flush_i;
                w_state_nxt      = RUN;
            end
            default: begin
                w_state_nxt = SETTLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_state      <= SETTLE;
            r_settle_cnt <= CW'(settle_cycles_p);
            r_flush_pend <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_settle_cnt <= w_settle_cnt_nxt;
            r_flush_pend <= w_flush_pend_nxt;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_n_i) begin
            assert (w_occupancy <= lg_size_p'(DEPTH));
        end
    end

endmodule

// File: tb/tb_bsg_async_fifo_wptr_ctrl.sv
// Bench for bsg_async_fifo_wptr_ctrl: directed scenarios then random traffic,
// checked against a cycle-level behavioural model of the write side.
module tb_bsg_async_fifo_wptr_ctrl;

    logic       clk;
    logic       reset_n;
    logic       v;
    logic       ready;
    logic       w_inc;
    logic [5:0] w_ptr_bin;
    logic [5:0] r_ptr_gray;
    logic       flush;
    logic       flush_done;
    logic       full;
    logic       almost_full;
    logic [5:0] occupancy;

    bsg_async_fifo_wptr_ctrl #(
        .lg_size_p           (6),
        .settle_cycles_p     (4),
        .almost_full_thresh_p(28)
    ) dut (
        .clk_i             (clk),
        .reset_n_i         (reset_n),
        .v_i               (v),
        .ready_o           (ready),
        .w_inc_o           (w_inc),
        .w_ptr_binary_i    (w_ptr_bin),
        .r_ptr_gray_wsync_i(r_ptr_gray),
        .flush_i           (flush),
        .flush_done_o      (flush_done),
        .full_o            (full),
        .almost_full_o     (almost_full),
        .occupancy_o       (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Behavioural model: pointers as plain numbers, mode as simple flags.
    logic [5:0] m_wptr, rd, rd_seen;
    int         settle_left;
    bit         in_drain, done_now, pend, m_valid;
    logic [5:0] exp_occ;
    bit         exp_full, exp_af, exp_ready, exp_inc, exp_fd;
    logic       s_inc, s_fd, s_ready, s_full;
    logic [5:0] s_occ;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task tick();
        w_ptr_bin  = m_wptr;
        r_ptr_gray = rd ^ (rd >> 1);
        @(negedge clk);
        exp_occ   = m_wptr - rd_seen;
        exp_full  = (exp_occ == 6'd32);
        exp_af    = (exp_occ >= 6'd28);
        exp_ready = (settle_left == 0) && !in_drain && !done_now && !exp_full;
        exp_inc   = v && exp_ready;
        exp_fd    = done_now;
        if (m_valid) begin
            chk("occupancy", 32'(occupancy), 32'(exp_occ));
            chk("full", 32'(full), 32'(exp_full));
            chk("almost_full", 32'(almost_full), 32'(exp_af));
            chk("ready", 32'(ready), 32'(exp_ready));
            chk("w_inc", 32'(w_inc), 32'(exp_inc));
            chk("flush_done", 32'(flush_done), 32'(exp_fd));
        end
        s_inc = w_inc; s_fd = flush_done; s_ready = ready; s_full = full; s_occ = occupancy;
        @(posedge clk);
        #1;
        if (!reset_n) begin
            settle_left = 4; in_drain = 0; done_now = 0; pend = 0;
            rd_seen = '0; m_wptr = '0; rd = '0; m_valid = 1;
        end else begin
            rd_seen = rd;
            m_wptr  = m_wptr + 6'(exp_inc);
            if (settle_left > 0) begin
                settle_left--; pend |= flush;
            end else if (in_drain) begin
                pend |= flush;
                if (exp_occ == 0) begin in_drain = 0; done_now = 1; end
            end else if (done_now) begin
                done_now = 0; pend |= flush;
            end else if (flush || pend) begin
                in_drain = 1; pend = 0;
            end
        end
    endtask

    int first, n_inc, n_fd, occ_cur;

    initial begin
        reset_n = 0; v = 0; flush = 0; rd = '0; m_wptr = '0; rd_seen = '0;
        settle_left = 4; in_drain = 0; done_now = 0; pend = 0; m_valid = 0;
        repeat (2) tick();

        // Settle length and burst fill against a stalled reader.
        reset_n = 1; v = 1; first = -1; n_inc = 0;
        for (int i = 1; i <= 50; i++) begin
            tick();
            if (s_inc === 1'b1) begin
                n_inc++;
                if (first < 0) first = i;
            end
        end
        chk("first_inc_cycle", first, 5);
        chk("burst_count", n_inc, 32);
        chk("full_at_32", 32'(s_full), 1);
        chk("not_ready_full", 32'(s_ready), 0);

        // Pointer wrap: write=2, read=60.
        reset_n = 0; v = 0; tick(); tick();
        reset_n = 1; m_wptr = 6'd2; rd = 6'd60;
        tick(); tick();
        chk("wrap_occ", 32'(s_occ), 6);
        chk("wrap_full", 32'(s_full), 0);

        // Flush with 5 entries outstanding, reader catches up one per cycle.
        reset_n = 0; tick();
        reset_n = 1; repeat (4) tick();
        v = 1; repeat (5) tick();
        v = 0; flush = 1; tick();
        flush = 0; tick();
        chk("drain_not_ready", 32'(s_ready), 0);
        n_fd = 0;
        for (int i = 0; i < 20; i++) begin
            if (rd != m_wptr) rd = rd + 6'd1;
            tick();
            if (s_fd === 1'b1) n_fd++;
        end
        chk("flush_done_count", n_fd, 1);
        chk("run_after_flush", 32'(s_ready), 1);

        // Write and flush in the same cycle.
        v = 1; flush = 1; tick();
        chk("inc_with_flush", 32'(s_inc), 1);
        flush = 0; tick();
        chk("drain_after_flush", 32'(s_ready), 0);
        v = 0; rd = m_wptr; repeat (5) tick();

        // Flush requested while settling.
        reset_n = 0; tick();
        reset_n = 1; flush = 1; tick();
        flush = 0; repeat (3) tick();
        tick(); chk("settle_flush_run", 32'(s_ready), 1);
        tick(); chk("settle_flush_drain", 32'(s_ready), 0);
        tick(); chk("settle_flush_done", 32'(s_fd), 1);

        // Reset while draining aborts the flush.
        v = 1; repeat (3) tick();
        v = 0; flush = 1; tick();
        flush = 0; repeat (2) tick();
        reset_n = 0; tick();
        reset_n = 1; n_fd = 0; first = -1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (s_fd === 1'b1) n_fd++;
            if (s_ready === 1'b1 && first < 0) first = i;
        end
        chk("abort_no_done", n_fd, 0);
        chk("abort_resettle", first, 5);

        // Random traffic with occasional flushes and resets.
        for (int i = 0; i < 3000; i++) begin
            reset_n = ($urandom_range(0, 299) != 0);
            v       = ($urandom_range(0, 3) != 0);
            flush   = ($urandom_range(0, 15) == 0);
            occ_cur = int'(6'(m_wptr - rd));
            if (occ_cur > 0 && $urandom_range(0, 2) == 0)
                rd = rd + 6'($urandom_range(0, occ_cur));
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
